// File: rtl/rc_add_sub_seq_if.sv
// rc_add_sub_seq_if: operand/result bus for rc_add_sub_seq.
// The signed-overflow flag V is present only when RC_ADD_SUB_SEQ_OVF_EN is defined.
interface rc_add_sub_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             SnA;
  logic [WIDTH-1:0] Y;
  logic             CO;
  logic             BUSY;
  logic             DONE;
`ifdef RC_ADD_SUB_SEQ_OVF_EN
  logic             V;
`endif

  // Requester side: issues operations, observes results.
  modport master (
    output START, A, B, SnA,
`ifdef RC_ADD_SUB_SEQ_OVF_EN
    input  V,
`endif
    input  Y, CO, BUSY, DONE
  );

  // Arithmetic unit side.
  modport slave (
    input  START, A, B, SnA,
`ifdef RC_ADD_SUB_SEQ_OVF_EN
    output V,
`endif
    output Y, CO, BUSY, DONE
  );
endinterface

// File: rtl/rc_add_sub_seq.sv
// rc_add_sub_seq: sequential adder/subtractor that processes SLICE bits per cycle, LSB first,
// over WIDTH/SLICE RUN cycles. Y/CO are registered and load only on the completion edge.
// Define RC_ADD_SUB_SEQ_OVF_EN to add the registered signed-overflow output V on the bus.
module rc_add_sub_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input logic             CLK,
  input logic             RST,
  rc_add_sub_seq_if.slave bus
);
  localparam int unsigned N    = WIDTH / SLICE;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0]  LastCnt = CntW'(N - 1);
  localparam logic [WIDTH-1:0] SegMask = WIDTH'({SLICE{1'b1}});

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic             w_capture;
  logic             w_busy;
  logic             w_done;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sna;
  logic [CntW-1:0]  r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_y;
  logic             r_co;

  logic [31:0]      w_off;
  logic [SLICE-1:0] w_a_seg;
  logic [SLICE-1:0] w_b_x;
  logic [SLICE:0]   w_seg_ext;
  logic [WIDTH-1:0] w_full;

  assign w_last = (r_cnt == LastCnt);

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode plus BUSY/DONE; START is only honoured outside RUN.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.START) begin
          w_capture    = 1'b1;
          w_state_next = StRun;
        end
      end
      StRun: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_state_next = StFin;
        end
      end
      StFin: begin
        w_done = 1'b1;
        if (bus.START) begin
          w_capture    = 1'b1;
          w_state_next = StRun;
        end else begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // One slice of the ripple add; B is inverted and carry seeded with SnA for subtraction.
  always_comb begin
    w_off     = 32'(r_cnt) * SLICE;
    w_a_seg   = SLICE'(r_a >> w_off);
    w_b_x     = SLICE'(r_b >> w_off) ^ {SLICE{r_sna}};
    w_seg_ext = {1'b0, w_a_seg} + {1'b0, w_b_x} + {{SLICE{1'b0}}, r_carry};
    // Partial sum with the current segment merged in, so the last edge can load Y directly.
    w_full    = (r_sum & ~(SegMask << w_off)) | (WIDTH'(w_seg_ext[SLICE-1:0]) << w_off);
  end

  // Operand capture, slice iteration and result registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sna   <= 1'b0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_y     <= '0;
      r_co    <= 1'b0;
    end else if (w_capture) begin
      r_a     <= bus.A;
      r_b     <= bus.B;
      r_sna   <= bus.SnA;
      r_cnt   <= '0;
      r_carry <= bus.SnA;
      r_sum   <= '0;
    end else if (r_state == StRun) begin
      r_sum   <= w_full;
      r_carry <= w_seg_ext[SLICE];
      r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
      if (w_last) begin
        r_y  <= w_full;
        r_co <= w_seg_ext[SLICE];
      end
    end
  end

`ifdef RC_ADD_SUB_SEQ_OVF_EN
  logic r_v;
  logic w_msb_cin;

  // Carry into the MSB recovered from its sum bit: s = a ^ b ^ cin.
  assign w_msb_cin = w_a_seg[SLICE-1] ^ w_b_x[SLICE-1] ^ w_seg_ext[SLICE-1];

  // Signed overflow flag, loaded alongside Y.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_v <= 1'b0;
    end else if (!w_capture && (r_state == StRun) && w_last) begin
      r_v <= w_msb_cin ^ w_seg_ext[SLICE];
    end
  end

  assign bus.V = r_v;
`endif

  assign bus.Y    = r_y;
  assign bus.CO   = r_co;
  assign bus.BUSY = w_busy;
  assign bus.DONE = w_done;
endmodule
